mc_control_unit: RTL and testbench
==================================

# mc_control_unit

Multicycle control unit for the RV32I datapath: a parametrised successor to the single-cycle decoder pair that sequences each instruction through fetch, decode, execute, memory and writeback states over a shared ALU and a single unified memory port. It sits beside the multicycle datapath, driving its mux selects and write strobes from the registered opcode fields and ALU flags. It adds wait-state handling via a memory ready handshake, the full branch-compare set, jal/jalr/lui, optional shifts, and a sticky illegal-instruction trap.

## Interface
- SHIFT_EN, 1: 1 decodes sll/srl/sra (and immediate forms); 0 sends them to ILLEGAL
- BRANCH_EXT, 1: 1 decodes blt/bge/bltu/bgeu; 0 supports beq/bne only, the others go to ILLEGAL
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- op  in  7  opcode from instruction register
- funct3  in  3  instruction [14:12]
- funct7_5  in  1  instruction [30]
- zero, lt, ltu  in  1 each  ALU flags of current ALU operation (equal, signed less, unsigned less)
- mem_ready  in  1  memory completes the access this cycle
- PCWrite, IRWrite, RegWrite, MemWrite  out  1 each  write strobes
- AdrSrc  out  1  0 = PC, 1 = ALUOut as memory address
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
- ALUSrcB  out  2  00 rs2, 01 imm, 10 constant 4
- ResultSrc  out  2  00 ALUOut, 01 memory data, 10 ALUResult
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- ALUControl  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra
- illegal  out  1  high while in ILLEGAL

## Operation
- State register reset to FETCH; outputs combinational from state, op/funct fields, flags and mem_ready.
- FETCH: AdrSrc=0, A=PC, B=4, add, ResultSrc=10; IRWrite=PCWrite=mem_ready; stays in FETCH until mem_ready, then DECODE.
- DECODE: A=OldPC, B=imm, add (branch/jal target into ALUOut); ImmSrc from op. Next: 0000011/0100011→MEMADR; 0110011→EXECR; 0010011→EXECI; 1100011→BRANCH; 1101111→JAL; 1100111 (funct3 000)→JALR; 0110111→LUI; anything else→ILLEGAL.
- MEMADR: A=rs1, B=imm, add → MEMREAD (lw, funct3 010) or MEMWRITE (sw, funct3 010); other funct3→ILLEGAL.
- MEMREAD: AdrSrc=1; waits for mem_ready → MEMWB. MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 held until mem_ready → FETCH.
- EXECR: A=rs1, B=rs2; EXECI: A=rs1, B=imm; both → ALUWB. ALU decode: 000 add, or sub if op[5]&funct7_5; 010 slt; 011 sltu; 100 xor; 110 or; 111 and; 001 sll; 101 srl/sra by funct7_5.
- ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
- BRANCH: A=rs1, B=rs2, sub, ResultSrc=00; PCWrite = taken; taken: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu; 010/011→ILLEGAL with no PCWrite. → FETCH.
- JAL: ResultSrc=00, PCWrite=1 (target), A=OldPC, B=4, add → ALUWB (rd=OldPC+4).
- JALR: A=rs1, B=imm, add, ResultSrc=10, PCWrite=1 → JALRWB: A=OldPC, B=4, add, ResultSrc=10, RegWrite=1 → FETCH.
- LUI: A=zero, B=imm (U), add → ALUWB.
- ILLEGAL: all strobes 0, illegal=1; absorbing until rst.
- Unlisted outputs in each state are 0/don't-care; strobes are never X.

## Timing
- Cycles with mem_ready=1 first try: branch 3, R/I/lui/sw/jal/jalr 4, lw 5; each mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE adds one.
- While rst high: state=FETCH, all four strobes and illegal forced 0; first fetch on the first edge after deassertion.
- Reset mid-instruction aborts it; no strobe fires after rst rises.
- mem_ready ignored outside FETCH/MEMREAD/MEMWRITE.

## Test plan
- add x3,x1,x2 (0x002081B3), mem_ready=1 → FETCH,DECODE,EXECR,ALUWB; ALUControl=0000; RegWrite only in cycle 4.
- lw (0x0000A183) with mem_ready low 2 cycles in MEMREAD → 7 cycles total, RegWrite with ResultSrc=01 once.
- blt (funct3 100) with lt=1 → PCWrite=1 in BRANCH; bgeu with ltu=1 → PCWrite=0; BRANCH_EXT=0 blt → illegal=1.
- jalr → JALR asserts PCWrite with ResultSrc=10, JALRWB asserts RegWrite with A=01, B=10.
- op=0x7F → ILLEGAL, illegal=1 held 10 cycles, strobes 0; rst → FETCH, illegal=0.
- SHIFT_EN=0, sll → ILLEGAL; SHIFT_EN=1 srai (funct7_5=1) → ALUControl=1001. Async rst asserted mid-MEMWRITE → MemWrite drops immediately.

Source files
------------

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle RV32I control FSM.
// Moves each instruction through FETCH, DECODE, EXECUTE, MEMORY and
// WRITEBACK states over a shared ALU and one unified memory port.
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   op, funct3, funct7_5  opcode fields from the instruction register
//   zero, lt, ltu         ALU flags (equal, signed less, unsigned less)
//   mem_ready             memory finishes its access this cycle
//   PCWrite, IRWrite, RegWrite, MemWrite   write strobes
//   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl  datapath selects
//   illegal               high while the FSM sits in ILLEGAL
//   state_dbg             current state code (see localparams below)
// Handshake: a memory access is in flight whenever the FSM is in FETCH,
// MEMREAD or MEMWRITE. It completes in the cycle where mem_ready is high.
// The FSM holds its state and selects until then. mem_ready has no effect
// in any other state.
`timescale 1ns/1ps
module mc_control_unit #(
  parameter bit SHIFT_EN   = 1'b1,
  parameter bit BRANCH_EXT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_JALRWB   = 4'd12;
  localparam logic [3:0] S_LUI      = 4'd13;
  localparam logic [3:0] S_ILLEGAL  = 4'd14;

  logic [3:0] state_q, state_d;
  logic       shift_ok;
  logic       br_legal, br_taken;
  logic [3:0] alu_dec;

  assign state_dbg = state_q;

  // Shift encodings fall into ILLEGAL when the shifter is not built.
  assign shift_ok = SHIFT_EN || !((funct3 == 3'b001) || (funct3 == 3'b101));

  // ALU operation for R/I-type execute. Only R-type (op[5]=1) may select
  // sub, because for addi bit 30 is part of the immediate.
  always_comb begin
    alu_dec = 4'b0000;
    case (funct3)
      3'b000: alu_dec = (op[5] && funct7_5) ? 4'b0001 : 4'b0000;
      3'b001: alu_dec = 4'b0111;
      3'b010: alu_dec = 4'b0101;
      3'b011: alu_dec = 4'b0110;
      3'b100: alu_dec = 4'b0100;
      3'b101: alu_dec = funct7_5 ? 4'b1001 : 4'b1000;
      3'b110: alu_dec = 4'b0011;
      3'b111: alu_dec = 4'b0010;
      default: alu_dec = 4'b0000;
    endcase
  end

  // Branch condition from the rs1-rs2 subtraction flags.
  always_comb begin
    br_legal = 1'b1;
    br_taken = 1'b0;
    case (funct3)
      3'b000: br_taken = zero;
      3'b001: br_taken = !zero;
      3'b100: br_taken = lt;
      3'b101: br_taken = !lt;
      3'b110: br_taken = ltu;
      3'b111: br_taken = !ltu;
      default: br_legal = 1'b0;
    endcase
    if (!BRANCH_EXT && funct3[2]) br_legal = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011: state_d = shift_ok ? S_EXECR : S_ILLEGAL;
          7'b0010011: state_d = shift_ok ? S_EXECI : S_ILLEGAL;
          7'b1100011: state_d = S_BRANCH;
          7'b1101111: state_d = S_JAL;
          7'b1100111: state_d = (funct3 == 3'b000) ? S_JALR : S_ILLEGAL;
          7'b0110111: state_d = S_LUI;
          default:    state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        if (funct3 == 3'b010) state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
        else                  state_d = S_ILLEGAL;
      end
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_LUI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = br_legal ? S_FETCH : S_ILLEGAL;
      S_JALR:     state_d = S_JALRWB;
      S_JALRWB:   state_d = S_FETCH;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_ILLEGAL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Immediate format depends on the opcode only.
  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      7'b0100011: ImmSrc = 3'b001;
      7'b1100011: ImmSrc = 3'b010;
      7'b1101111: ImmSrc = 3'b011;
      7'b0110111: ImmSrc = 3'b100;
      default:    ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 4'b0000;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = 4'b0001;
        PCWrite    = br_taken && br_legal;
      end
      // PC takes the target already in ALUOut while the ALU forms OldPC+4.
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      S_JALRWB: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        RegWrite  = 1'b1;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
      end
      S_ILLEGAL: illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
    // The state flop resets asynchronously to FETCH, but FETCH strobes
    // follow mem_ready. Mask them so nothing fires while rst is held.
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
`timescale 1ns/1ps
module tb_mc_control_unit;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
    S_MEMREAD = 4'd3, S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6,
    S_EXECI = 4'd7, S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10,
    S_JALR = 4'd11, S_JALRWB = 4'd12, S_LUI = 4'd13, S_ILLEGAL = 4'd14;

  localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LW = 7'h03,
    OP_SW = 7'h23, OP_BR = 7'h63, OP_JAL = 7'h6F, OP_JALR = 7'h67,
    OP_LUI = 7'h37, OP_BAD = 7'h7F;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5, zero, lt, ltu, mem_ready;

  logic       a_pcw, a_irw, a_rw, a_mw, a_adr, a_ill;
  logic [1:0] a_srca, a_srcb, a_res;
  logic [2:0] a_imm;
  logic [3:0] a_alu, a_state;
  logic       b_pcw, b_irw, b_rw, b_mw, b_adr, b_ill;
  logic [1:0] b_srca, b_srcb, b_res;
  logic [2:0] b_imm;
  logic [3:0] b_alu, b_state;

  mc_control_unit #(.SHIFT_EN(1'b1), .BRANCH_EXT(1'b1)) u_a (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .PCWrite(a_pcw), .IRWrite(a_irw), .RegWrite(a_rw), .MemWrite(a_mw),
    .AdrSrc(a_adr), .ALUSrcA(a_srca), .ALUSrcB(a_srcb), .ResultSrc(a_res),
    .ImmSrc(a_imm), .ALUControl(a_alu), .illegal(a_ill), .state_dbg(a_state));

  mc_control_unit #(.SHIFT_EN(1'b0), .BRANCH_EXT(1'b0)) u_b (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .PCWrite(b_pcw), .IRWrite(b_irw), .RegWrite(b_rw), .MemWrite(b_mw),
    .AdrSrc(b_adr), .ALUSrcA(b_srca), .ALUSrcB(b_srcb), .ResultSrc(b_res),
    .ImmSrc(b_imm), .ALUControl(b_alu), .illegal(b_ill), .state_dbg(b_state));

  // scoreboard
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [3:0] flg;   // {zero, lt, ltu, mem_ready}
    logic [3:0] st;
    logic [3:0] strb;  // {PCWrite, IRWrite, RegWrite, MemWrite}
    logic       adr;
    logic [1:0] a, b, res;
    logic [3:0] alu;
    logic       ill;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic row(input logic [6:0] op_i, input logic [2:0] f3_i, input logic f7_i,
                     input logic [3:0] flg_i, input logic [3:0] st_i, input logic [3:0] strb_i,
                     input logic adr_i, input logic [1:0] a_i, input logic [1:0] b_i,
                     input logic [1:0] res_i, input logic [3:0] alu_i, input logic ill_i);
    vec_t v;
    v.op = op_i; v.f3 = f3_i; v.f7 = f7_i; v.flg = flg_i; v.st = st_i; v.strb = strb_i;
    v.adr = adr_i; v.a = a_i; v.b = b_i; v.res = res_i; v.alu = alu_i; v.ill = ill_i;
    vq.push_back(v);
  endtask

  function automatic logic [31:0] pack_a();
    return {12'd0, a_state, a_pcw, a_irw, a_rw, a_mw, a_adr, a_srca, a_srcb, a_res, a_alu, a_ill};
  endfunction

  function automatic logic [31:0] pack_exp(input vec_t v);
    return {12'd0, v.st, v.strb, v.adr, v.a, v.b, v.res, v.alu, v.ill};
  endfunction

  // {care, ImmSrc}; R-type and unknown opcodes have no immediate.
  function automatic logic [3:0] exp_imm(input logic [6:0] o);
    case (o)
      OP_LW, OP_I, OP_JALR: return 4'b1000;
      OP_SW:  return 4'b1001;
      OP_BR:  return 4'b1010;
      OP_JAL: return 4'b1011;
      OP_LUI: return 4'b1100;
      default: return 4'b0000;
    endcase
  endfunction

  // driver tasks
  task automatic set_in(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic [3:0] flg);
    op = o; funct3 = f3; funct7_5 = f7;
    {zero, lt, ltu, mem_ready} = flg;
  endtask

  task automatic cyc(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic [3:0] flg);
    @(negedge clk);
    set_in(o, f3, f7, flg);
    #1;
  endtask

  // Hold reset for one cycle with mem_ready high, confirm strobes are masked,
  // then release with mem_ready low so FETCH idles until the next cyc().
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_in(7'h00, 3'b000, 1'b0, 4'b0001);
    #1;
    chk("rst_strobes_a", 32'({a_pcw, a_irw, a_rw, a_mw, a_ill}), 32'd0);
    chk("rst_strobes_b", 32'({b_pcw, b_irw, b_rw, b_mw, b_ill}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    set_in(7'h00, 3'b000, 1'b0, 4'b0001);

    // add x3,x1,x2 (0x002081B3); mem_ready ignored in DECODE/ALUWB
    row(OP_R, 3'b000, 1'b0, 4'b0001, S_FETCH,  4'b1100, 1'b0, 2'b00, 2'b10, 2'b10, 4'h0, 1'b0);
    row(OP_R, 3'b000, 1'b0, 4'b0000, S_DECODE, 4'b0000, 1'b0, 2'b01, 2'b01, 2'b00, 4'h0, 1'b0);
    row(OP_R, 3'b000, 1'b0, 4'b0000, S_EXECR,  4'b0000, 1'b0, 2'b10, 2'b00, 2'b00, 4'h0, 1'b0);
    row(OP_R, 3'b000, 1'b0, 4'b0001, S_ALUWB,  4'b0010, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0);
    // sub
    row(OP_R, 3'b000, 1'b1, 4'b0001, S_FETCH,  4'b1100, 1'b0, 2'b00, 2'b10, 2'b10, 4'h0, 1'b0);
    row(OP_R, 3'b000, 1'b1, 4'b0001, S_DECODE, 4'b0000, 1'b0, 2'b01, 2'b01, 2'b00, 4'h0, 1'b0);
    row(OP_R, 3'b000, 1'b1, 4'b0001, S_EXECR,  4'b0000, 1'b0, 2'b10, 2'b00, 2'b00, 4'h1, 1'b0);
    row(OP_R, 3'b000, 1'b1, 4'b0001, S_ALUWB,  4'b0010, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0);
    // sltu
    row(OP_R, 3'b011, 1'b0, 4'b0001, S_FETCH,  4'b1100, 1'b0, 2'b00, 2'b10, 2'b10, 4'h0, 1'b0);
    row(OP_R, 3'b011, 1'b0, 4'b0001, S_DECODE, 4'b0000, 1'b0, 2'b01, 2'b01, 2'b00, 4'h0, 1'b0);
    row(OP_R, 3'b011, 1'b0, 4'b0001, S_EXECR,  4'b0000, 1'b0, 2'b10, 2'b00, 2'b00, 4'h6, 1'b0);
    row(OP_R, 3'b011, 1'b0, 4'b0001, S_ALUWB,  4'b0010, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0);
    // addi with instr[30]=1: still add
    row(OP_I, 3'b000, 1'b1, 4'b0001, S_FETCH,  4'b1100, 1'b0, 2'b00, 2'b10, 2'b10, 4'h0, 1'b0);
    row(OP_I, 3'b000, 1'b1, 4'b0001, S_DECODE, 4'b0000, 1'b0, 2'b01, 2'b01, 2'b00, 4'h0, 1'b0);
    row(OP_I, 3'b000, 1'b1, 4'b0001, S_EXECI,  4'b0000, 1'b0, 2'b10, 2'b01, 2'b00, 4'h0, 1'b0);
    row(OP_I, 3'b000, 1'b1, 4'b0001, S_ALUWB,  4'b0010, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0);
    // srai
    row(OP_I, 3'b101, 1'b1, 4'b0001, S_FETCH,  4'b1100, 1'b0, 2'b00, 2'b10, 2'b10, 4'h0, 1'b0);
    row(OP_I, 3'b101, 1'b1, 4'b0001, S_DECODE, 4'b0000, 1'b0, 2'b01, 2'b01, 2'b00, 4'h0, 1'b0);
    row(OP_I, 3'b101, 1'b1, 4'b0001, S_EXECI,  4'b0000, 1'b0, 2'b10, 2'b01, 2'b00, 4'h9, 1'b0);
    row(OP_I, 3'b101, 1'b1, 4'b0001, S_ALUWB,  4'b0010, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0);
    // lw (0x0000A183) with two wait states in MEMREAD: 7 cycles
    row(OP_LW, 3'b010, 1'b0, 4'b0001, S_FETCH,   4'b1100, 1'b0, 2'b00, 2'b10, 2'b10, 4'h0, 1'b0);
    row(OP_LW, 3'b010, 1'b0, 4'b0000, S_DECODE,  4'b0000, 1'b0, 2'b01, 2'b01, 2'b00, 4'h0, 1'b0);
    row(OP_LW, 3'b010, 1'b0, 4'b0000, S_MEMADR,  4'b0000, 1'b0, 2'b10, 2'b01, 2'b00, 4'h0, 1'b0);
    row(OP_LW, 3'b010, 1'b0, 4'b0000, S_MEMREAD, 4'b0000, 1'b1, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0);
    row(OP_LW, 3'b010, 1'b0, 4'b0000, S_MEMREAD, 4'b0000, 1'b1, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0);
    row(OP_LW, 3'b010, 1'b0, 4'b0001, S_MEMREAD, 4'b0000, 1'b1, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0);
    row(OP_LW, 3'b010, 1'b0, 4'b0000, S_MEMWB,   4'b0010, 1'b0, 2'b00, 2'b00, 2'b01, 4'h0, 1'b0);
    // sw with one fetch wait and one write wait
    row(OP_SW, 3'b010, 1'b0, 4'b0000, S_FETCH,    4'b0000, 1'b0, 2'b00, 2'b10, 2'b10, 4'h0, 1'b0);
    row(OP_SW, 3'b010, 1'b0, 4'b0001, S_FETCH,    4'b1100, 1'b0, 2'b00, 2'b10, 2'b10, 4'h0, 1'b0);
    row(OP_SW, 3'b010, 1'b0, 4'b0001, S_DECODE,   4'b0000, 1'b0, 2'b01, 2'b01, 2'b00, 4'h0, 1'b0);
    row(OP_SW, 3'b010, 1'b0, 4'b0001, S_MEMADR,   4'b0000, 1'b0, 2'b10, 2'b01, 2'b00, 4'h0, 1'b0);
    row(OP_SW, 3'b010, 1'b0, 4'b0000, S_MEMWRITE, 4'b0001, 1'b1, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0);
    row(OP_SW, 3'b010, 1'b0, 4'b0001, S_MEMWRITE, 4'b0001, 1'b1, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0);
    // blt, lt=1: taken
    row(OP_BR, 3'b100, 1'b0, 4'b0101, S_FETCH,  4'b1100, 1'b0, 2'b00, 2'b10, 2'b10, 4'h0, 1'b0);
    row(OP_BR, 3'b100, 1'b0, 4'b0101, S_DECODE, 4'b0000, 1'b0, 2'b01, 2'b01, 2'b00, 4'h0, 1'b0);
    row(OP_BR, 3'b100, 1'b0, 4'b0101, S_BRANCH, 4'b1000, 1'b0, 2'b10, 2'b00, 2'b00, 4'h1, 1'b0);
    // bgeu, ltu=1: not taken
    row(OP_BR, 3'b111, 1'b0, 4'b0011, S_FETCH,  4'b1100, 1'b0, 2'b00, 2'b10, 2'b10, 4'h0, 1'b0);
    row(OP_BR, 3'b111, 1'b0, 4'b0011, S_DECODE, 4'b0000, 1'b0, 2'b01, 2'b01, 2'b00, 4'h0, 1'b0);
    row(OP_BR, 3'b111, 1'b0, 4'b0011, S_BRANCH, 4'b0000, 1'b0, 2'b10, 2'b00, 2'b00, 4'h1, 1'b0);
    // bne, zero=0: taken
    row(OP_BR, 3'b001, 1'b0, 4'b0001, S_FETCH,  4'b1100, 1'b0, 2'b00, 2'b10, 2'b10, 4'h0, 1'b0);
    row(OP_BR, 3'b001, 1'b0, 4'b0001, S_DECODE, 4'b0000, 1'b0, 2'b01, 2'b01, 2'b00, 4'h0, 1'b0);
    row(OP_BR, 3'b001, 1'b0, 4'b0001, S_BRANCH, 4'b1000, 1'b0, 2'b10, 2'b00, 2'b00, 4'h1, 1'b0);
    // jal
    row(OP_JAL, 3'b000, 1'b0, 4'b0001, S_FETCH,  4'b1100, 1'b0, 2'b00, 2'b10, 2'b10, 4'h0, 1'b0);
    row(OP_JAL, 3'b000, 1'b0, 4'b0001, S_DECODE, 4'b0000, 1'b0, 2'b01, 2'b01, 2'b00, 4'h0, 1'b0);
    row(OP_JAL, 3'b000, 1'b0, 4'b0001, S_JAL,    4'b1000, 1'b0, 2'b01, 2'b10, 2'b00, 4'h0, 1'b0);
    row(OP_JAL, 3'b000, 1'b0, 4'b0001, S_ALUWB,  4'b0010, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0);
    // jalr
    row(OP_JALR, 3'b000, 1'b0, 4'b0001, S_FETCH,  4'b1100, 1'b0, 2'b00, 2'b10, 2'b10, 4'h0, 1'b0);
    row(OP_JALR, 3'b000, 1'b0, 4'b0001, S_DECODE, 4'b0000, 1'b0, 2'b01, 2'b01, 2'b00, 4'h0, 1'b0);
    row(OP_JALR, 3'b000, 1'b0, 4'b0001, S_JALR,   4'b1000, 1'b0, 2'b10, 2'b01, 2'b10, 4'h0, 1'b0);
    row(OP_JALR, 3'b000, 1'b0, 4'b0001, S_JALRWB, 4'b0010, 1'b0, 2'b01, 2'b10, 2'b10, 4'h0, 1'b0);
    // lui
    row(OP_LUI, 3'b000, 1'b0, 4'b0001, S_FETCH,  4'b1100, 1'b0, 2'b00, 2'b10, 2'b10, 4'h0, 1'b0);
    row(OP_LUI, 3'b000, 1'b0, 4'b0001, S_DECODE, 4'b0000, 1'b0, 2'b01, 2'b01, 2'b00, 4'h0, 1'b0);
    row(OP_LUI, 3'b000, 1'b0, 4'b0001, S_LUI,    4'b0000, 1'b0, 2'b11, 2'b01, 2'b00, 4'h0, 1'b0);
    row(OP_LUI, 3'b000, 1'b0, 4'b0001, S_ALUWB,  4'b0010, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0);
    // unknown opcode 0x7F: ILLEGAL, held for 10 cycles
    row(OP_BAD, 3'b000, 1'b0, 4'b0001, S_FETCH,  4'b1100, 1'b0, 2'b00, 2'b10, 2'b10, 4'h0, 1'b0);
    row(OP_BAD, 3'b000, 1'b0, 4'b0001, S_DECODE, 4'b0000, 1'b0, 2'b01, 2'b01, 2'b00, 4'h0, 1'b0);
    for (int k = 0; k < 10; k++)
      row(OP_BAD, 3'b000, 1'b0, 4'(k), S_ILLEGAL, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 1'b1);

    // reset state, mem_ready high
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", 32'(a_state), 32'(S_FETCH));
    chk("reset_strobes", 32'({a_pcw, a_irw, a_rw, a_mw, a_ill}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      logic [3:0] ie;
      set_in(vq[i].op, vq[i].f3, vq[i].f7, vq[i].flg);
      #1;
      chk($sformatf("row%0d", i), pack_a(), pack_exp(vq[i]));
      ie = exp_imm(vq[i].op);
      if (vq[i].st == S_DECODE && ie[3])
        chk($sformatf("row%0d_imm", i), 32'(a_imm), 32'(ie[2:0]));
      @(negedge clk);
    end

    // rst clears the absorbing ILLEGAL state
    rst = 1'b1;
    #1;
    chk("illegal_rst_ill", 32'(a_ill), 32'd0);
    chk("illegal_rst_state", 32'(a_state), 32'(S_FETCH));
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;

    // sll: unit B has no shifter
    do_reset();
    repeat (3) cyc(OP_R, 3'b001, 1'b0, 4'b0001);
    chk("a_sll_alu", 32'(a_alu), 32'h7);
    chk("b_sll_ill", 32'(b_ill), 32'd1);
    chk("b_sll_strb", 32'({b_pcw, b_irw, b_rw, b_mw}), 32'd0);

    // blt lt=1: unit B lacks the extended compares
    do_reset();
    repeat (3) cyc(OP_BR, 3'b100, 1'b0, 4'b0101);
    chk("a_blt_pcw", 32'(a_pcw), 32'd1);
    chk("b_blt_pcw", 32'(b_pcw), 32'd0);
    cyc(OP_BR, 3'b100, 1'b0, 4'b0100);
    chk("b_blt_ill", 32'(b_ill), 32'd1);
    chk("a_blt_done", 32'({a_state, a_ill}), 32'({S_FETCH, 1'b0}));

    // beq zero=1: taken on both units
    do_reset();
    repeat (3) cyc(OP_BR, 3'b000, 1'b0, 4'b1001);
    chk("a_beq_pcw", 32'(a_pcw), 32'd1);
    chk("b_beq_pcw", 32'(b_pcw), 32'd1);
    cyc(OP_BR, 3'b000, 1'b0, 4'b1000);
    chk("b_beq_done", 32'(b_state), 32'(S_FETCH));

    // branch funct3 010: no PCWrite, then ILLEGAL
    do_reset();
    repeat (3) cyc(OP_BR, 3'b010, 1'b0, 4'b1001);
    chk("br010_pcw", 32'(a_pcw), 32'd0);
    cyc(OP_BR, 3'b010, 1'b0, 4'b1001);
    chk("br010_ill", 32'(a_ill), 32'd1);

    // jalr with funct3 != 000
    do_reset();
    repeat (3) cyc(OP_JALR, 3'b001, 1'b0, 4'b0001);
    chk("jalr_f3_ill", 32'(a_state), 32'(S_ILLEGAL));

    // sw with funct3 000 fails after MEMADR
    do_reset();
    repeat (3) cyc(OP_SW, 3'b000, 1'b0, 4'b0001);
    chk("sb_memadr", 32'(a_state), 32'(S_MEMADR));
    cyc(OP_SW, 3'b000, 1'b0, 4'b0001);
    chk("sb_ill", 32'(a_ill), 32'd1);

    // async reset in the middle of a stalled MEMWRITE
    do_reset();
    repeat (3) cyc(OP_SW, 3'b010, 1'b0, 4'b0001);
    cyc(OP_SW, 3'b010, 1'b0, 4'b0000);
    chk("sw_mw_before", 32'(a_mw), 32'd1);
    #2;
    mem_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("sw_mw_rst", 32'({a_pcw, a_irw, a_rw, a_mw}), 32'd0);
    chk("sw_state_rst", 32'(a_state), 32'(S_FETCH));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_fetch", 32'({a_state, a_irw, a_pcw}), 32'({S_FETCH, 2'b11}));
    @(negedge clk);
    #1;
    chk("post_rst_decode", 32'(a_state), 32'(S_DECODE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
